// File: rtl/arb_rr_lock_reg.sv
// Round-robin arbiter that never interleaves multi-beat packets and feeds a one-entry output register slice.
// One cycle latency, one beat per cycle. Under downstream backpressure the slice holds and no requester is accepted.
module arb_rr_lock_reg #(
  parameter int  WIDTH     = 4,
  parameter int  PLD_WIDTH = 32,
  localparam int ID_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     v_vld_s,
  output logic [WIDTH-1:0]     v_rdy_s,
  input  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH],
  input  logic [WIDTH-1:0]     v_last_s,
  output logic                 vld_m,
  input  logic                 rdy_m,
  output logic [PLD_WIDTH-1:0] pld_m,
  output logic                 last_m,
  output logic [ID_W-1:0]      gnt_id_m
);

  typedef enum logic {UNLOCK, LOCK} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] lock_id;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] sel_inc;
  logic            found;
  logic            load;
  logic            xfer;

  // Gating with rst_n keeps every requester un-accepted while reset is held.
  assign load = rst_n & (~vld_m | rdy_m);

  // Rotating priority search starting at ptr, wrapping at WIDTH (not 2**ID_W).
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!found && v_vld_s[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign sel     = (state == LOCK) ? lock_id : winner;
  assign sel_inc = (sel == ID_W'(WIDTH - 1)) ? '0 : sel + 1'b1;

  // While locked the owner keeps the channel even when it idles.
  always_comb begin
    v_rdy_s = '0;
    if (load) begin
      if (state == LOCK) begin
        v_rdy_s[lock_id] = 1'b1;
      end else if (found) begin
        v_rdy_s[winner] = 1'b1;
      end
    end
  end

  assign xfer = |(v_vld_s & v_rdy_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_m    <= 1'b0;
      pld_m    <= '0;
      last_m   <= 1'b0;
      gnt_id_m <= '0;
      ptr      <= '0;
      lock_id  <= '0;
      state    <= UNLOCK;
    end else if (load) begin
      vld_m <= xfer;
      if (xfer) begin
        pld_m    <= v_pld_s[sel];
        last_m   <= v_last_s[sel];
        gnt_id_m <= sel;
        if (v_last_s[sel]) begin
          state <= UNLOCK;
          ptr   <= sel_inc;
        end else begin
          state   <= LOCK;
          lock_id <= sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_rr_lock_reg.sv
// Directed and randomized checks of the round-robin lock arbiter with its output register slice.
module tb_arb_rr_lock_reg;
  localparam int W  = 4;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  v_vld_s;
  logic [W-1:0]  v_rdy_s;
  logic [PW-1:0] v_pld_s [W];
  logic [W-1:0]  v_last_s;
  logic          vld_m;
  logic          rdy_m;
  logic [PW-1:0] pld_m;
  logic          last_m;
  logic [1:0]    gnt_id_m;

  int errors = 0;
  int checks = 0;

  logic [34:0] sb [$];
  logic [34:0] exp_beat;
  logic [15:0] seq [W];
  int          wait_pk [W];
  logic [W-1:0] inpkt;
  logic [W-1:0] act;
  logic [W-1:0] acc;
  logic        prev_last;
  logic [1:0]  prev_gnt;
  logic        drain;

  always #5 clk = ~clk;

  arb_rr_lock_reg #(.WIDTH(W), .PLD_WIDTH(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .v_vld_s  (v_vld_s),
    .v_rdy_s  (v_rdy_s),
    .v_pld_s  (v_pld_s),
    .v_last_s (v_last_s),
    .vld_m    (vld_m),
    .rdy_m    (rdy_m),
    .pld_m    (pld_m),
    .last_m   (last_m),
    .gnt_id_m (gnt_id_m)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rdy_m    = 1'b1;
    v_vld_s  = '1;
    v_last_s = '1;
    for (int i = 0; i < W; i++) v_pld_s[i] = 32'h100 + i;

    // Reset holds everything idle even with all requesters valid
    repeat (2) @(negedge clk);
    #1;
    check("rst_vld", vld_m, 0);
    check("rst_rdy", v_rdy_s, 0);
    check("rst_gnt", gnt_id_m, 0);
    check("rst_last", last_m, 0);
    check("rst_pld", pld_m, 0);

    // Fairness: all valid, single-beat packets
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("fair_rdy0", v_rdy_s, 4'b0001);
    check("fair_vld0", vld_m, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      check("fair_vld", vld_m, 1);
      check("fair_gnt", gnt_id_m, (k - 1) % 4);
      check("fair_pld", pld_m, 32'h100 + (k - 1) % 4);
      check("fair_rdy", v_rdy_s, 64'(1) << (k % 4));
    end
    @(negedge clk);
    v_vld_s = '0;
    #1;
    check("fair_gnt_end", gnt_id_m, 0);
    check("idle_rdy", v_rdy_s, 0);
    @(negedge clk);
    #1;
    check("idle_vld", vld_m, 0);

    // Lock: ptr=1, req1 sends three beats while req0/req2 wait
    v_vld_s  = 4'b0111;
    v_last_s = 4'b1101;
    v_pld_s[1] = 32'h1A1;
    #1;
    check("lk_rdy1", v_rdy_s, 4'b0010);
    @(negedge clk);
    #1;
    check("lk_gnt1", gnt_id_m, 1);
    check("lk_last1", last_m, 0);
    check("lk_pld1", pld_m, 32'h1A1);
    v_pld_s[1] = 32'h1A2;
    #1;
    check("lk_rdy2", v_rdy_s, 4'b0010);
    @(negedge clk);
    #1;
    check("lk_gnt2", gnt_id_m, 1);
    check("lk_pld2", pld_m, 32'h1A2);
    v_pld_s[1]  = 32'h1A3;
    v_last_s[1] = 1'b1;
    #1;
    check("lk_rdy3", v_rdy_s, 4'b0010);
    @(negedge clk);
    #1;
    check("lk_gnt3", gnt_id_m, 1);
    check("lk_last3", last_m, 1);
    check("lk_pld3", pld_m, 32'h1A3);
    v_vld_s     = 4'b0101;
    v_last_s[2] = 1'b0;
    v_pld_s[2]  = 32'h2B1;
    #1;
    check("lk_rdy_r2", v_rdy_s, 4'b0100);
    @(negedge clk);
    #1;
    check("lk_gnt_r2a", gnt_id_m, 2);
    check("lk_last_r2a", last_m, 0);
    v_pld_s[2]  = 32'h2B2;
    v_last_s[2] = 1'b1;
    #1;
    check("lk_rdy_r2b", v_rdy_s, 4'b0100);
    @(negedge clk);
    #1;
    check("lk_gnt_r2b", gnt_id_m, 2);
    check("lk_pld_r2b", pld_m, 32'h2B2);
    v_vld_s = 4'b0001;
    #1;
    check("lk_rdy_wrap", v_rdy_s, 4'b0001);
    @(negedge clk);
    #1;
    check("lk_gnt_r0", gnt_id_m, 0);

    // Backpressure: output frozen, nothing accepted, then no-bubble reload
    rdy_m       = 1'b0;
    v_vld_s     = 4'b1001;
    v_last_s[3] = 1'b0;
    v_pld_s[3]  = 32'h3C1;
    #1;
    check("bp_rdy0", v_rdy_s, 0);
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      #1;
      check("bp_vld", vld_m, 1);
      check("bp_gnt", gnt_id_m, 0);
      check("bp_pld", pld_m, 32'h100);
      check("bp_last", last_m, 1);
      check("bp_rdy", v_rdy_s, 0);
    end
    rdy_m = 1'b1;
    #1;
    check("bp_release_rdy", v_rdy_s, 4'b1000);

    // Lock bubble: req3 locked and idle, req0 must not be served
    @(negedge clk);
    #1;
    check("bub_vld", vld_m, 1);
    check("bub_gnt", gnt_id_m, 3);
    check("bub_pld", pld_m, 32'h3C1);
    v_vld_s = 4'b0001;
    #1;
    check("bub_rdy1", v_rdy_s, 4'b1000);
    @(negedge clk);
    #1;
    check("bub_vld1", vld_m, 0);
    check("bub_rdy2", v_rdy_s, 4'b1000);
    @(negedge clk);
    #1;
    check("bub_vld2", vld_m, 0);
    v_vld_s     = 4'b1001;
    v_pld_s[3]  = 32'h3C2;
    v_last_s[3] = 1'b1;
    #1;
    check("bub_rdy3", v_rdy_s, 4'b1000);
    @(negedge clk);
    #1;
    check("bub_gnt_end", gnt_id_m, 3);
    check("bub_last_end", last_m, 1);
    check("bub_pld_end", pld_m, 32'h3C2);
    check("bub_ptr_wrap", v_rdy_s, 4'b0001);

    // Reset mid-packet abandons the lock
    @(negedge clk);
    #1;
    check("mrst_gnt0", gnt_id_m, 0);
    v_last_s[3] = 1'b0;
    v_pld_s[3]  = 32'h3D1;
    #1;
    check("mrst_rdy3", v_rdy_s, 4'b1000);
    @(negedge clk);
    #1;
    check("mrst_locked_gnt", gnt_id_m, 3);
    rst_n = 1'b0;
    #1;
    check("mrst_vld", vld_m, 0);
    check("mrst_rdy", v_rdy_s, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    v_vld_s  = 4'b1010;
    v_last_s = 4'b1111;
    #1;
    check("mrst_first_rdy", v_rdy_s, 4'b0010);
    @(negedge clk);
    #1;
    check("mrst_first_gnt", gnt_id_m, 1);
    check("mrst_first_pld", pld_m, 32'h1A3);
    v_vld_s = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rnd_vld", vld_m, 0);

    // Random traffic with scoreboard
    for (int i = 0; i < W; i++) begin
      seq[i]     = '0;
      wait_pk[i] = 0;
    end
    inpkt     = '0;
    act       = '0;
    prev_last = 1'b1;
    prev_gnt  = '0;
    for (int cyc = 0; cyc < 10300; cyc++) begin
      @(negedge clk);
      drain = (cyc >= 10000);
      rdy_m = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int i = 0; i < W; i++) begin
        if (!act[i] && (drain ? inpkt[i] : ($urandom_range(0, 1) == 1))) begin
          act[i]      = 1'b1;
          v_pld_s[i]  = {8'(i), 8'h5A, seq[i]};
          v_last_s[i] = drain ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
      end
      v_vld_s = act;
      #1;
      if (vld_m && rdy_m) begin
        check("rnd_sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          check("rnd_gnt", gnt_id_m, exp_beat[34:33]);
          check("rnd_last", last_m, exp_beat[32]);
          check("rnd_pld", pld_m, exp_beat[31:0]);
        end
        if (!prev_last) check("rnd_contig", gnt_id_m, prev_gnt);
        prev_last = last_m;
        prev_gnt  = gnt_id_m;
      end
      acc = v_vld_s & v_rdy_s;
      check("rnd_onehot", $countones(acc) <= 1, 1);
      for (int i = 0; i < W; i++) begin
        if (acc[i]) begin
          sb.push_back({2'(i), v_last_s[i], v_pld_s[i]});
          if (!inpkt[i]) check("rnd_wait", wait_pk[i] < W, 1);
          wait_pk[i] = 0;
          inpkt[i]   = !v_last_s[i];
          seq[i]     = seq[i] + 16'd1;
          act[i]     = 1'b0;
        end
      end
      for (int j = 0; j < W; j++) begin
        if (acc[j] && v_last_s[j]) begin
          for (int i = 0; i < W; i++) begin
            if (i != j && act[i] && !inpkt[i]) wait_pk[i]++;
          end
        end
      end
    end
    #1;
    check("end_sb_empty", sb.size(), 0);
    check("end_vld", vld_m, 0);
    check("end_pending", act, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
